// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port byte-enable data RAM for the MEM stage, zero-swept after every reset.
// Latency: stores commit at the accept edge; loads return RD_LAT cycles after the accept edge.
// Backpressure: ready low during the clear sweep and RD_LAT-1 cycles per load; requests while not ready are dropped.
module data_mem_ctrl #(
  parameter int DW     = 16,
  parameter int AW     = 3,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   rdata,
  output logic            rvalid,
  output logic            ready,
  output logic            stall
);
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {INIT, IDLE, RWAIT} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic [2:0]    lat_q, lat_d;
  logic [DW-1:0] cap_q, cap_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          ready_q, ready_d;

  logic [DW-1:0] mem_q [DEPTH];

  // single write port shared by the clear sweep and pipeline stores
  logic          mem_wr;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdat;
  logic [NB-1:0] mem_wbe;

  // next-state, write-port steering and registered output values
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    lat_d      = lat_q;
    cap_d      = cap_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    ready_d    = ready_q;
    mem_wr     = 1'b0;
    mem_waddr  = addr;
    mem_wdat   = wdata;
    mem_wbe    = be;
    case (state_q)
      INIT: begin
        // clear one word per edge; requests are ignored until the sweep ends
        mem_wr     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdat   = '0;
        mem_wbe    = '1;
        init_cnt_d = init_cnt_q + AW'(1);
        if (&init_cnt_q) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (req) begin
          if (we) begin
            mem_wr = 1'b1;
          end else if (RD_LAT == 1) begin
            rdata_d  = mem_q[addr];
            rvalid_d = 1'b1;
          end else begin
            // word is captured now so later stores cannot change the returned data
            cap_d   = mem_q[addr];
            lat_d   = 3'(RD_LAT - 1);
            state_d = RWAIT;
            ready_d = 1'b0;
          end
        end
      end
      RWAIT: begin
        lat_d = lat_q - 3'd1;
        if (lat_q == 3'd1) begin
          state_d  = IDLE;
          rdata_d  = cap_q;
          rvalid_d = 1'b1;
          ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = INIT;
        ready_d = 1'b0;
      end
    endcase
  end

  // control and output registers; reset also discards any in-flight load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      lat_q      <= '0;
      cap_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      lat_q      <= lat_d;
      cap_q      <= cap_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      ready_q    <= ready_d;
    end
  end

  // byte-lane array write; contents are left alone while reset is held
  always_ff @(posedge clk) begin
    if (rst_n && mem_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_wbe[i]) mem_q[mem_waddr][8*i +: 8] <= mem_wdat[8*i +: 8];
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign ready  = ready_q;
  assign stall  = ~ready_q;

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data memory for the MEM stage of the five-stage pipeline. It is a single-port synchronous RAM with per-byte store enables, a configurable read latency, and a request/ready handshake that gives the pipeline a stall signal. After every reset it clears its own contents with a built-in sweep, so the array is deterministic without an `initial` block. It replaces the fixed 16-bit by 8-word store/load memory.

## Interface
Parameters:
- DW, 16: data width in bits; must be a multiple of 8, minimum 8.
- AW, 3: word-address width; depth DEPTH = 2**AW words.
- RD_LAT, 1: read latency in cycles; legal range 1..4.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1 = store, 0 = load; qualifies req.
- addr  in  AW  word address.
- wdata  in  DW  store data.
- be  in  DW/8  byte-lane store enables; be[i] covers wdata[8i+7:8i].
- rdata  out  DW  load data; valid only while rvalid=1, otherwise holds its last value.
- rvalid  out  1  one-cycle pulse marking load data.
- ready  out  1  block can accept a request this cycle.
- stall  out  1  equal to ~ready; drives the pipeline hazard unit.

## Operation
State machine states: INIT, IDLE, RWAIT.

- **Reset** (rst_n=0 at an edge):
  - Outputs: rdata=0, rvalid=0, ready=0.
  - Internal: init counter=0, state=INIT.
  - Any in-flight load is discarded and no rvalid is produced for it.
  - Array contents are not touched during reset itself.
- **INIT:**
  - Each edge writes 0 to mem[counter], then increments the counter.
  - The edge that writes DEPTH-1 moves the FSM to IDLE.
  - req is ignored throughout INIT.
- **IDLE** (ready=1):
  - Store (req=1, we=1) at edge k: every lane with be[i]=1 is written at edge k; lanes with be[i]=0 keep their value. be=0 is accepted as a no-op. Stores produce no rvalid, and the FSM stays in IDLE.
  - Load (req=1, we=0) at edge k: array word mem[addr] is captured at edge k.
    - RD_LAT=1: rdata is updated and rvalid=1 in the cycle after edge k; the FSM stays in IDLE.
    - RD_LAT>1: the FSM enters RWAIT with a latency counter loaded with RD_LAT-1.
- **RWAIT** (ready=0):
  - The counter decrements each edge.
  - The edge where the counter reaches 0 returns the FSM to IDLE, drives rdata with the captured word, and pulses rvalid=1.
  - req is ignored throughout RWAIT.
- **General rules:**
  - Requests seen while ready=0 are dropped, not queued; the pipeline must hold them.
  - Only one access is accepted per edge. A load issued the cycle after a store to the same address returns the new data.
  - rvalid is never asserted for two consecutive cycles unless RD_LAT=1 and loads are issued back-to-back.

## Timing
- After rst_n rises, the first edge with rst_n=1 clears address 0. The edge numbered DEPTH clears address DEPTH-1. ready=1 from the cycle after that edge, i.e. DEPTH cycles after reset release.
- Load latency is exactly RD_LAT: a request accepted at edge k gives rvalid=1 in the cycle after edge k+RD_LAT-1.
- ready is low for RD_LAT-1 cycles per load. It is high again in the rvalid cycle, so a new request can be accepted during the rvalid cycle.
- Store throughput is one per cycle. Load throughput is one per RD_LAT cycles.
- Mid-operation reset (rst_n low in INIT or RWAIT) takes effect at that edge: ready=0, rvalid=0, and INIT restarts from address 0.
- All outputs are registered. There is no combinational path from req, we, or addr to any output.

## Test plan
- **Reset sweep** (DW=16, AW=3, RD_LAT=1): preload words with stores, then pulse rst_n low for 1 cycle → ready=0 for exactly 8 cycles, then ready=1; loads of all 8 addresses return 0x0000.
- **Byte-lane store:** store 0xABCD to addr 5 with be=2'b11, then store 0x1234 with be=2'b01 → load of addr 5 returns 0xAB34, with rvalid for one cycle.
- **Latency sweep:** RD_LAT=3, store 0x00FF to addr 2, then load addr 2 →
  - ready=0 for 2 cycles;
  - rvalid=1 exactly 3 cycles after the accept edge;
  - rdata=0x00FF.
  - req held high during RWAIT with addr=7 is ignored (no extra rvalid).
- **Back-to-back** (RD_LAT=1): loads of addr 0,1,2 on consecutive cycles → three consecutive rvalid pulses with the stored values in order. A store then an immediate load to the same address returns the new data.
- **Reset during RWAIT** (RD_LAT=4): assert rst_n=0 two cycles after a load accept → rvalid is never asserted for that load, rdata=0, and INIT takes 8 cycles again.
- **Wide config** (DW=32, AW=4): store 0xDEADBEEF with be=4'b1010 over cleared memory → load returns 0xDE00BE00; address 15 is reachable and cleared after reset.
